// File: rtl/morse_pkg.sv
// Shared constants and types for the Morse symbol decoder: classifier element
// codes, decoder FSM states and the fixed ASCII characters it can emit.
package morse_pkg;

  localparam logic [1:0] CODE_WAIT = 2'b00;
  localparam logic [1:0] CODE_DOT  = 2'b01;
  localparam logic [1:0] CODE_DASH = 2'b10;
  localparam logic [1:0] CODE_SEND = 2'b11;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    COLLECT  = 2'd1,
    OVERFLOW = 2'd2
  } state_e;

endpackage

// File: rtl/morse_lut.sv
// ITU Morse lookup: element i of the pattern sits at bit i (dot=0, dash=1),
// unused upper bits are zero. Unknown (len, pattern) pairs report hit=0.
module morse_lut (
  input  logic [2:0] len,
  input  logic [4:0] pattern,
  output logic [7:0] ascii,
  output logic       hit
);

  logic [7:0] key_s;
  assign key_s = {len, pattern};

  // Table lookup keyed on length and element bits
  always_comb begin
    ascii = 8'h00;
    hit   = 1'b1;
    case (key_s)
      {3'd2, 5'b00010}: ascii = 8'h41; // A .-
      {3'd4, 5'b00001}: ascii = 8'h42; // B
      {3'd4, 5'b00101}: ascii = 8'h43;
      {3'd3, 5'b00001}: ascii = 8'h44;
      {3'd1, 5'b00000}: ascii = 8'h45;
      {3'd4, 5'b00100}: ascii = 8'h46;
      {3'd3, 5'b00011}: ascii = 8'h47;
      {3'd4, 5'b00000}: ascii = 8'h48;
      {3'd2, 5'b00000}: ascii = 8'h49;
      {3'd4, 5'b01110}: ascii = 8'h4A;
      {3'd3, 5'b00101}: ascii = 8'h4B;
      {3'd4, 5'b00010}: ascii = 8'h4C;
      {3'd2, 5'b00011}: ascii = 8'h4D;
      {3'd2, 5'b00001}: ascii = 8'h4E;
      {3'd3, 5'b00111}: ascii = 8'h4F;
      {3'd4, 5'b00110}: ascii = 8'h50;
      {3'd4, 5'b01011}: ascii = 8'h51;
      {3'd3, 5'b00010}: ascii = 8'h52;
      {3'd3, 5'b00000}: ascii = 8'h53;
      {3'd1, 5'b00001}: ascii = 8'h54;
      {3'd3, 5'b00100}: ascii = 8'h55;
      {3'd4, 5'b01000}: ascii = 8'h56;
      {3'd3, 5'b00110}: ascii = 8'h57;
      {3'd4, 5'b01001}: ascii = 8'h58;
      {3'd4, 5'b01101}: ascii = 8'h59;
      {3'd4, 5'b00011}: ascii = 8'h5A;
      {3'd5, 5'b11111}: ascii = 8'h30; // digits are all five elements long
      {3'd5, 5'b11110}: ascii = 8'h31;
      {3'd5, 5'b11100}: ascii = 8'h32;
      {3'd5, 5'b11000}: ascii = 8'h33;
      {3'd5, 5'b10000}: ascii = 8'h34;
      {3'd5, 5'b00000}: ascii = 8'h35;
      {3'd5, 5'b00001}: ascii = 8'h36;
      {3'd5, 5'b00011}: ascii = 8'h37;
      {3'd5, 5'b00111}: ascii = 8'h38;
      {3'd5, 5'b01111}: ascii = 8'h39;
      default: begin
        ascii = 8'h00;
        hit   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/morse_symbol_decoder.sv
// Accumulates dot/dash events from the press classifier into a pattern and, on
// a send event, emits the decoded ASCII character on a valid/ready output.
module morse_symbol_decoder
  import morse_pkg::*;
#(
  parameter int         MAX_ELEMS      = 5,
  parameter bit         SPACE_ON_EMPTY = 1'b1,
  parameter logic [7:0] ERR_CHAR       = 8'h3F
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] sym_code,
  output logic [7:0] char_data,
  output logic       char_valid,
  input  logic       char_ready,
  output logic [2:0] pat_len,
  output logic       decode_err,
  output logic       drop_err
);

  localparam logic [2:0] MAX_LEN = 3'(MAX_ELEMS);

  logic [1:0] prev_q;
  state_e     state_q, state_d;
  logic [4:0] pattern_q, pattern_d;
  logic [2:0] len_q, len_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       dec_err_q, dec_err_d;
  logic       drop_q, drop_d;

  logic       event_s, elem_ev_s, send_ev_s, out_free_s;
  logic [7:0] lut_ascii_s;
  logic       lut_hit_s;

  morse_lut u_lut (
    .len     (len_q),
    .pattern (pattern_q),
    .ascii   (lut_ascii_s),
    .hit     (lut_hit_s)
  );

  // A held code is only one event: it must differ from last cycle's code.
  assign event_s    = (sym_code != prev_q) && (sym_code != CODE_WAIT);
  assign elem_ev_s  = event_s && (sym_code != CODE_SEND);
  assign send_ev_s  = event_s && (sym_code == CODE_SEND);
  assign out_free_s = !valid_q || char_ready;

  // Next-state, pattern accumulation and output-register logic
  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    len_d     = len_q;
    data_d    = data_q;
    valid_d   = valid_q;
    dec_err_d = 1'b0;
    drop_d    = 1'b0;

    if (valid_q && char_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    if (elem_ev_s) begin
      case (state_q)
        EMPTY: begin
          pattern_d = {4'b0000, sym_code == CODE_DASH};
          len_d     = 3'd1;
          state_d   = COLLECT;
        end
        COLLECT: begin
          if (len_q == MAX_LEN) begin
            state_d = OVERFLOW;
          end else begin
            pattern_d[len_q] = (sym_code == CODE_DASH);
            len_d            = len_q + 3'd1;
          end
        end
        OVERFLOW: state_d = OVERFLOW;
        default:  state_d = EMPTY;
      endcase
    end else if (send_ev_s) begin
      if (state_q == EMPTY) begin
        if (SPACE_ON_EMPTY && out_free_s) begin
          valid_d = 1'b1;
          data_d  = ASCII_SPACE;
        end else if (SPACE_ON_EMPTY) begin
          drop_d = 1'b1;
        end else begin
          drop_d = 1'b0;
        end
      end else if (out_free_s) begin
        valid_d   = 1'b1;
        pattern_d = 5'b00000;
        len_d     = 3'd0;
        state_d   = EMPTY;
        if ((state_q == OVERFLOW) || !lut_hit_s) begin
          data_d    = ERR_CHAR;
          dec_err_d = 1'b1;
        end else begin
          data_d = lut_ascii_s;
        end
      end else begin
        // Output still occupied: keep the pattern so the user can resend.
        drop_d = 1'b1;
      end
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q    <= CODE_WAIT;
      state_q   <= EMPTY;
      pattern_q <= 5'b00000;
      len_q     <= 3'd0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      dec_err_q <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      prev_q    <= sym_code;
      state_q   <= state_d;
      pattern_q <= pattern_d;
      len_q     <= len_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      dec_err_q <= dec_err_d;
      drop_q    <= drop_d;
    end
  end

  assign char_data  = data_q;
  assign char_valid = valid_q;
  assign pat_len    = len_q;
  assign decode_err = dec_err_q;
  assign drop_err   = drop_q;

endmodule
